idma_wr_burst_gen: RTL
======================

# idma_wr_burst_gen

Write-side burst generator for the 128-bit iDMA write path. It drains the SRAM-backed sync FIFO, which presents data with a registered output and treats pop as ready, and turns one task descriptor into AXI-style AW/W/B traffic. Bursts are cut at BURST_LEN and at 4 KB boundaries. The block is the consumer counterpart of the read-side DMA that fills the FIFO.

## Interface
Parameters:
- DATA_W, 128, beat width; bytes per beat BPB = DATA_W/8
- ADDR_W, 32, address width
- LEN_W, 16, task beat-count width
- BURST_LEN, 16, max beats per burst (1..256)
- OST_MAX, 4, max AW bursts awaiting B

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- task_start  in  1  start pulse, accepted only when task_busy=0
- task_addr  in  ADDR_W  start byte address; low log2(BPB) bits treated as 0
- task_beats  in  LEN_W  total beats to write
- task_busy  out  1  task in progress
- task_done  out  1  one-cycle pulse at task completion
- task_err  out  1  error status, valid with task_done
- fifo_empty  in  1  FIFO output not valid
- fifo_data  in  DATA_W  FIFO output data
- fifo_pop  out  1  FIFO ready/pop
- awvalid / awready  out / in  1  AW handshake
- awaddr  out  ADDR_W  burst address
- awlen  out  8  beats-1
- wvalid / wready  out / in  1  W handshake
- wdata  out  DATA_W  write data
- wlast  out  1  last beat of burst
- bvalid  in  1  B response valid
- bready  out  1  B ready
- bresp  in  2  B response code

## Operation
- FSM states: IDLE, AW, W, WAIT_B.
- IDLE + task_start:
  - Latch addr and beats; task_busy=1.
  - beats==0: go to WAIT_B (no AW issued).
  - Otherwise go to AW.
- Burst length blen = min(remaining, BURST_LEN, (4096 - addr[11:0])/BPB). Computed with ADDR_W+1-bit intermediates so there is no truncation.
- AW:
  - awvalid=1 only while outstanding < OST_MAX.
  - awaddr, awlen = blen-1 held stable until awready.
  - On handshake: addr += blen*BPB, remaining -= blen, go to W.
- W:
  - wvalid = !fifo_empty; wdata = fifo_data; fifo_pop = wvalid & wready (combinational).
  - A beat counter runs up to blen; wlast=1 on beat blen.
  - On the wlast handshake: go to AW if remaining>0, else WAIT_B.
- WAIT_B: when outstanding==0, pulse task_done, clear task_busy, go to IDLE.
- bready is constant 1. outstanding increments on AW handshake and decrements on B handshake; both in one cycle leaves it unchanged.
- task_start while busy: ignored.
- Address wrap above 2^ADDR_W: modulo wrap, no error.

## Timing
- Reset values:
  - Outputs: task_busy=0, task_done=0, task_err=0, awvalid=0, awaddr=0, awlen=0, wvalid=0, wlast=0, fifo_pop=0, bready=1.
  - State IDLE, outstanding=0.
- awvalid rises the cycle after task_start is accepted.
- First W beat can issue the cycle after the AW handshake.
- Zero-gap bursts: the next awvalid comes the cycle after the wlast handshake.
- task_done rises the cycle after the last B handshake, or 2 cycles after task_start when beats==0.
- Throughput is 1 beat/cycle with wready=1 and FIFO non-empty. There are no pops without a handshake.
- Reset mid-task abandons all state immediately. The FIFO is reinitialised by its owner.

## Configuration
- IDMA_WR_BRESP_CHK_EN defined:
  - A sticky error flag sets on any B handshake with bresp!=0.
  - task_err shows the flag during the task_done cycle.
  - The flag clears on the next accepted task_start.
- Undefined: task_err is tied 0 and bresp is ignored.

## Test plan
- FIFO prefilled, task addr 0x1000, beats 16 → one AW 0x1000/awlen 15; 16 W beats in order, wlast on 16th; task_done 1 cycle after B.
- addr 0x0FC0, beats 8 → AW 0x0FC0/len 3 then AW 0x1000/len 3; no burst crosses 4 KB.
- addr 0x2000, beats 37 → awlen 15, 15, 4 at 0x2000, 0x2100, 0x2200; 37 pops total.
- Random wready and fifo_empty gaps → fifo_pop only on wvalid&wready; data sequence and beat count exact; awaddr/awlen stable while awvalid=1 and awready=0.
- bvalid held low, beats 80 → exactly 4 AW handshakes, 5th awvalid withheld until one B returns; same-cycle AW+B keeps count.
- With IDMA_WR_BRESP_CHK_EN, bresp=2 on 2nd of 3 bursts → task_err=1 with task_done, 0 on the next clean task. Without the macro → task_err=0. Also beats=0 → no AW, task_done pulse.

Source files
------------

// File: rtl/idma_wr_burst_gen.sv
// Write-side burst generator: drains the sync FIFO into AW/W/B bursts cut at BURST_LEN and 4 KB pages.
// Define IDMA_WR_BRESP_CHK_EN to report non-OKAY B responses on task_err.
module idma_wr_burst_gen #(
    parameter int DATA_W    = 128,
    parameter int ADDR_W    = 32,
    parameter int LEN_W     = 16,
    parameter int BURST_LEN = 16,
    parameter int OST_MAX   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              task_start,
    input  logic [ADDR_W-1:0] task_addr,
    input  logic [LEN_W-1:0]  task_beats,
    output logic              task_busy,
    output logic              task_done,
    output logic              task_err,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_pop,
    output logic              awvalid,
    input  logic              awready,
    output logic [ADDR_W-1:0] awaddr,
    output logic [7:0]        awlen,
    output logic              wvalid,
    input  logic              wready,
    output logic [DATA_W-1:0] wdata,
    output logic              wlast,
    input  logic              bvalid,
    output logic              bready,
    input  logic [1:0]        bresp
);

    localparam int BPB   = DATA_W / 8;
    localparam int OFF_W = $clog2(BPB);
    localparam int CW    = ((ADDR_W > LEN_W) ? ADDR_W : LEN_W) + 1;
    localparam int OST_W = $clog2(OST_MAX + 1);

    typedef enum logic [1:0] {IDLE, AW, W, WAIT_B} state_t;

    state_t             state;
    logic [ADDR_W-1:0]  addr;
    logic [LEN_W-1:0]   remaining;
    logic [7:0]         beat_cnt;
    logic [OST_W-1:0]   outstanding;
    logic [OST_W-1:0]   outstanding_nxt;
    logic [ADDR_W-1:0]  start_addr;
    logic               aw_hs;
    logic               w_hs;
    logic               b_hs;

    // Beats to the next 4 KB page are at least 1, so blen never reaches 0 while remaining > 0.
    function automatic logic [8:0] calc_blen(input logic [11:0] page_off, input logic [LEN_W-1:0] rem);
        logic [CW-1:0] to_page;
        logic [CW-1:0] blen;
        to_page = (CW'(4096) - CW'(page_off)) >> OFF_W;
        blen    = CW'(rem);
        if (blen > CW'(BURST_LEN)) blen = CW'(BURST_LEN);
        if (blen > to_page)        blen = to_page;
        return 9'(blen);
    endfunction

    assign start_addr = task_addr & ~ADDR_W'(BPB - 1);

    assign awvalid  = (state == AW) && (outstanding < OST_W'(OST_MAX));
    assign awaddr   = addr;
    assign wvalid   = (state == W) && !fifo_empty;
    assign wdata    = fifo_data;
    assign wlast    = (state == W) && (beat_cnt == awlen);
    assign fifo_pop = wvalid && wready;
    assign bready   = 1'b1;

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;
    assign b_hs  = bvalid && bready;

    always_comb begin
        outstanding_nxt = outstanding;
        if (aw_hs && !b_hs)      outstanding_nxt = outstanding + OST_W'(1);
        else if (!aw_hs && b_hs) outstanding_nxt = outstanding - OST_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            addr        <= '0;
            remaining   <= '0;
            awlen       <= '0;
            beat_cnt    <= '0;
            outstanding <= '0;
            task_busy   <= 1'b0;
            task_done   <= 1'b0;
        end else begin
            task_done   <= 1'b0;
            outstanding <= outstanding_nxt;
            case (state)
                IDLE: begin
                    if (task_start) begin
                        task_busy <= 1'b1;
                        addr      <= start_addr;
                        remaining <= task_beats;
                        beat_cnt  <= '0;
                        if (task_beats == '0) begin
                            state <= WAIT_B;
                        end else begin
                            awlen <= 8'(calc_blen(start_addr[11:0], task_beats) - 9'd1);
                            state <= AW;
                        end
                    end
                end
                AW: begin
                    if (aw_hs) begin
                        addr      <= addr + ((ADDR_W'(awlen) + ADDR_W'(1)) << OFF_W);
                        remaining <= remaining - LEN_W'(awlen) - LEN_W'(1);
                        state     <= W;
                    end
                end
                W: begin
                    if (w_hs) begin
                        if (wlast) begin
                            beat_cnt <= '0;
                            // addr/remaining already point past this burst
                            if (remaining != '0) begin
                                awlen <= 8'(calc_blen(addr[11:0], remaining) - 9'd1);
                                state <= AW;
                            end else begin
                                state <= WAIT_B;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + 8'd1;
                        end
                    end
                end
                WAIT_B: begin
                    if (outstanding_nxt == '0) begin
                        task_done <= 1'b1;
                        task_busy <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef IDMA_WR_BRESP_CHK_EN
    logic err_flag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_flag <= 1'b0;
        end else if (state == IDLE && task_start) begin
            err_flag <= 1'b0;
        end else if (b_hs && bresp != 2'b00) begin
            err_flag <= 1'b1;
        end
    end

    assign task_err = task_done && err_flag;
`else
    logic bresp_unused;

    assign bresp_unused = ^bresp;
    assign task_err     = 1'b0;
`endif

endmodule
